// File: rtl/tlk2711_pkg.sv
// Shared types, character constants and the CRC-16-CCITT step for the TLK2711 TX framer.
// The CRC state exists only when TLK_FRAME_CRC_EN is defined.
package tlk2711_pkg;

  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam logic [7:0]  D5_6     = 8'hC5;
  localparam logic [7:0]  D11_5    = 8'hAB;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    MODE_NORM     = 2'd0,
    MODE_LOOPBACK = 2'd1,
    MODE_KCODE    = 2'd2,
    MODE_PRBS     = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMA,
    ST_SOF,
    ST_DATA,
`ifdef TLK_FRAME_CRC_EN
    ST_CRC,
`endif
    ST_LOOP,
    ST_KCODE,
    ST_PRBS
  } state_e;

  // Everything the framer drives off-chip, registered as one bundle.
  typedef struct packed {
    logic [15:0] txd;
    logic        tkmsb;
    logic        tklsb;
    logic        loopen;
    logic        prbsen;
    logic        enable;
    logic        lckrefn;
    logic        busy;
    logic        stop_ack;
  } tx_out_t;

  // One 16-bit word, MSB first, through the CCITT polynomial.
  function automatic logic [15:0] crc16_ccitt_step(input logic [15:0] crc,
                                                   input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/tlk2711_crc16.sv
// Word-wide CRC-16-CCITT accumulator: clr reloads the init value, en folds in one word.
module tlk2711_crc16
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc_q <= CRC_INIT;
    else if (clr_i) crc_q <= CRC_INIT;
    else if (en_i)  crc_q <= crc16_ccitt_step(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 TX framer / mode controller: NORM framing, loopback, K-code and PRBS modes.
// Define TLK_FRAME_CRC_EN to append a CRC-16-CCITT word after each payload.
module tlk2711_tx_framer
  import tlk2711_pkg::*;
#(
  parameter int         NUM_COMMA   = 2,
  parameter int         PAYLOAD_LEN = 32,
  parameter logic [7:0] IDLE_CHAR   = D5_6,
  parameter logic [7:0] SOF_CHAR    = D11_5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic        i_stop,
  output logic        o_stop_ack,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] o_txd,
  output logic        o_tkmsb,
  output logic        o_tklsb,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_enable,
  output logic        o_lckrefn,
  output logic        o_testen,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam logic [3:0]  LAST_COMMA = 4'(NUM_COMMA - 1);
  localparam logic [15:0] LAST_WORD  = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0] COMMA_WORD = {IDLE_CHAR, K28_5};
  localparam logic [15:0] SOF_WORD   = {SOF_CHAR, K28_5};

  state_e      state_q, state_d;
  logic [3:0]  comma_cnt_q, comma_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        start_prev_q;
  tx_out_t     out_q, out_d;

  logic   start_ok, xfer, last_xfer, frame_end;
  state_e after_frame;

  assign start_ok    = i_start & ~start_prev_q & ~i_stop;
  assign s_ready     = (state_q == ST_DATA);
  assign xfer        = s_ready & s_valid;
  assign last_xfer   = xfer && (pay_cnt_q == LAST_WORD);
  assign after_frame = i_stop ? ST_IDLE : ST_COMMA;

`ifdef TLK_FRAME_CRC_EN
  logic [15:0] crc_value;

  tlk2711_crc16 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == ST_SOF),
    .en_i   (xfer),
    .data_i (s_data),
    .crc_o  (crc_value)
  );

  assign frame_end = (state_q == ST_CRC);
`else
  assign frame_end = last_xfer;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          case (mode_e'(i_mode))
            MODE_NORM:     state_d = ST_COMMA;
            MODE_LOOPBACK: state_d = ST_LOOP;
            MODE_KCODE:    state_d = ST_KCODE;
            default:       state_d = ST_PRBS;
          endcase
        end
      end
      ST_COMMA: if (comma_cnt_q == LAST_COMMA) state_d = ST_SOF;
      ST_SOF:   state_d = ST_DATA;
`ifdef TLK_FRAME_CRC_EN
      ST_DATA:  if (last_xfer) state_d = ST_CRC;
      ST_CRC:   state_d = after_frame;
`else
      ST_DATA:  if (last_xfer) state_d = after_frame;
`endif
      ST_LOOP, ST_KCODE, ST_PRBS: if (i_stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d          = '0;
    out_d.lckrefn  = 1'b1;
    out_d.enable   = (state_q != ST_IDLE);
    out_d.busy     = (state_q != ST_IDLE);
    out_d.loopen   = (state_q == ST_LOOP);
    out_d.prbsen   = (state_q == ST_PRBS);
    // The previous cycle was busy and we now sit in IDLE: that is a completed stop.
    out_d.stop_ack = (state_q == ST_IDLE) && out_q.busy;
    case (state_q)
      ST_COMMA, ST_LOOP, ST_KCODE: begin
        out_d.txd   = COMMA_WORD;
        out_d.tklsb = 1'b1;
      end
      ST_SOF: begin
        out_d.txd   = SOF_WORD;
        out_d.tklsb = 1'b1;
      end
      ST_DATA: begin
        out_d.txd   = s_valid ? s_data : COMMA_WORD;
        out_d.tklsb = ~s_valid;
      end
`ifdef TLK_FRAME_CRC_EN
      ST_CRC:  out_d.txd = crc_value;
`endif
      default: ;
    endcase
  end

  always_comb begin
    comma_cnt_d = comma_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_COMMA)
      comma_cnt_d = (comma_cnt_q == LAST_COMMA) ? 4'd0 : comma_cnt_q + 4'd1;
    if (xfer)
      pay_cnt_d = last_xfer ? 16'd0 : pay_cnt_q + 16'd1;
    if ((state_q == ST_IDLE) && start_ok) frame_cnt_d = 16'd0;
    else if (frame_end)                   frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comma_cnt_q  <= 4'd0;
      pay_cnt_q    <= 16'd0;
      frame_cnt_q  <= 16'd0;
      start_prev_q <= 1'b1;  // a start held through reset must not fire
      out_q        <= '0;
    end else begin
      comma_cnt_q  <= comma_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      start_prev_q <= i_start;
      out_q        <= out_d;
    end
  end

  assign o_txd       = out_q.txd;
  assign o_tkmsb     = out_q.tkmsb;
  assign o_tklsb     = out_q.tklsb;
  assign o_loopen    = out_q.loopen;
  assign o_prbsen    = out_q.prbsen;
  assign o_enable    = out_q.enable;
  assign o_lckrefn   = out_q.lckrefn;
  assign o_busy      = out_q.busy;
  assign o_stop_ack  = out_q.stop_ack;
  assign o_testen    = 1'b0;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Scoreboard bench for tlk2711_tx_framer (NUM_COMMA=2, PAYLOAD_LEN=4); honours TLK_FRAME_CRC_EN.
module tb_tlk2711_tx_framer;

  localparam int NUM_COMMA   = 2;
  localparam int PAYLOAD_LEN = 4;
  // {tkmsb, tklsb, txd}
  localparam logic [17:0] COMMA_W = 18'h1C5BC;
  localparam logic [17:0] SOF_W   = 18'h1ABBC;

  typedef struct packed {
    logic [17:0] word;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_stop;
  logic [1:0]  i_mode;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        o_stop_ack;
  logic [15:0] o_txd;
  logic        o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen, o_busy;
  logic [15:0] o_frame_cnt;

  exp_t exp_q[$];
  int   plan_q[$];
  int   exp_fc;
  int   n_checks = 0;
  int   n_errors = 0;

  tlk2711_tx_framer #(
    .NUM_COMMA   (NUM_COMMA),
    .PAYLOAD_LEN (PAYLOAD_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_stop      (i_stop),
    .o_stop_ack  (o_stop_ack),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .o_txd       (o_txd),
    .o_tkmsb     (o_tkmsb),
    .o_tklsb     (o_tklsb),
    .o_loopen    (o_loopen),
    .o_prbsen    (o_prbsen),
    .o_enable    (o_enable),
    .o_lckrefn   (o_lckrefn),
    .o_testen    (o_testen),
    .o_busy      (o_busy),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

`ifdef TLK_FRAME_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [15:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int b = 15; b >= 0; b--)
      c = (c << 1) ^ ((c[15] ^ d[b]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
`endif

  // Queue the expected line words for one frame and the matching payload plan (-1 = gap).
  task automatic plan_frame(input int gap_len);
    logic [15:0] d;
`ifdef TLK_FRAME_CRC_EN
    logic [15:0] crc;
    crc = 16'hFFFF;
`endif
    for (int i = 0; i < NUM_COMMA; i++) exp_q.push_back('{word: COMMA_W, last: 1'b0});
    exp_q.push_back('{word: SOF_W, last: 1'b0});
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      d = 16'h1000 + 16'(i);
      plan_q.push_back(int'(d));
      exp_q.push_back('{word: {2'b00, d}, last: 1'b0});
`ifdef TLK_FRAME_CRC_EN
      crc = crc_model(crc, d);
`endif
      if (i == 1)
        for (int g = 0; g < gap_len; g++) begin
          plan_q.push_back(-1);
          exp_q.push_back('{word: COMMA_W, last: 1'b0});
        end
    end
`ifdef TLK_FRAME_CRC_EN
    exp_q.push_back('{word: {2'b00, crc}, last: 1'b1});
`else
    exp_q[exp_q.size() - 1].last = 1'b1;
`endif
  endtask

  // NORM run of n_frames; i_stop rises during the 2nd payload word of the last frame.
  task automatic run_norm(input int n_frames, input int gap_len);
    int   budget, words, p;
    exp_t e;
    exp_q.delete();
    plan_q.delete();
    for (int f = 0; f < n_frames; f++) plan_frame(gap_len);
    exp_fc = 0;
    words  = 0;
    budget = 0;
    @(negedge clk);
    i_mode  = 2'd0;
    i_start = 1'b1;
    while (exp_q.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      i_start = 1'b0;
      if (o_enable) begin
        e = exp_q.pop_front();
        check("norm_word", 32'({o_tkmsb, o_tklsb, o_txd}), 32'(e.word));
        check("norm_mode_pins", 32'({o_loopen, o_prbsen, o_testen}), 32'd0);
        if (e.last) begin
          exp_fc++;
          check("frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
        end
      end
      if (s_ready && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p < 0) begin
          s_valid = 1'b0;
          s_data  = 16'h0000;
        end else begin
          s_valid = 1'b1;
          s_data  = p[15:0];
          words++;
          if (words == (n_frames - 1) * PAYLOAD_LEN + 2) i_stop = 1'b1;
        end
      end else begin
        s_valid = 1'b1;  // must be ignored while s_ready is low
        s_data  = 16'hDEAD;
      end
    end
    check("norm_stream_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("stop_idle_pins", 32'({o_enable, o_busy, o_stop_ack, o_lckrefn, o_loopen, o_prbsen}),
          32'b001100);
    check("stop_idle_txd", 32'({o_tkmsb, o_tklsb, o_txd}), 32'd0);
    i_stop  = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("stop_ack_pulse", 32'(o_stop_ack), 32'd0);
    check("frame_cnt_hold", 32'(o_frame_cnt), 32'(n_frames));
  endtask

  task automatic start_mode(input logic [1:0] m, input string tag);
    int n;
    @(negedge clk);
    i_mode  = m;
    i_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      n++;
    end while (!o_busy && n < 6);
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic stop_mode(input string tag);
    int n;
    i_stop = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_stop_ack && n < 30);
    check({tag, "_ack"}, 32'(o_stop_ack), 32'd1);
    check({tag, "_idle"}, 32'({o_enable, o_prbsen, o_loopen, o_busy, o_lckrefn, o_txd}),
          32'({5'b00001, 16'h0000}));
    i_stop = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, 32'(o_stop_ack), 32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_mode  = 2'd0;
    s_data  = 16'h0000;
    s_valid = 1'b0;

    #1;
    check("reset_outputs", 32'({o_txd, o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable,
                                o_lckrefn, o_testen, o_busy, o_stop_ack, s_ready}), 32'd0);
    check("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_lckrefn", 32'({o_lckrefn, o_enable, o_busy, o_txd}), 32'({3'b100, 16'h0000}));

    // Continuous frames, then the 10-word frame with a 3-word underrun.
    run_norm(2, 0);
    run_norm(1, 3);

    // Stop has priority over a start edge in IDLE.
    @(negedge clk);
    i_stop  = 1'b1;
    i_mode  = 2'd3;
    i_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stop_blocks_start", 32'({o_busy, o_enable}), 32'd0);
    end
    i_start = 1'b0;
    i_stop  = 1'b0;

    start_mode(2'd3, "prbs");
    check("prbs_pins", 32'({o_enable, o_loopen, o_prbsen, o_tkmsb, o_tklsb}), 32'b10100);
    check("prbs_txd", 32'(o_txd), 32'd0);
    check("prbs_frame_cnt_clr", 32'(o_frame_cnt), 32'd0);
    stop_mode("prbs_stop");

    start_mode(2'd2, "kcode");
    repeat (4) begin
      check("kcode_word", 32'({o_tkmsb, o_tklsb, o_txd}), 32'(COMMA_W));
      check("kcode_pins", 32'({o_enable, o_loopen, o_prbsen}), 32'b100);
      @(negedge clk);
    end
    stop_mode("kcode_stop");

    start_mode(2'd1, "loop");
    check("loop_word", 32'({o_tkmsb, o_tklsb, o_txd}), 32'(COMMA_W));
    check("loop_pins", 32'({o_enable, o_loopen, o_prbsen}), 32'b110);
    stop_mode("loop_stop");

    // Reset mid-DATA of the second frame, with i_start held through the release.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    start_mode(2'd0, "rst_norm");
    n = 0;
    while (!(s_ready && o_frame_cnt == 16'd1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_data", 32'({s_ready, o_frame_cnt}), 32'({1'b1, 16'd1}));
    i_start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({o_txd, o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable,
                                      o_lckrefn, o_testen, o_busy, o_stop_ack, s_ready}), 32'd0);
    check("async_reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("held_start_ignored", 32'({o_busy, o_enable, o_lckrefn}), 32'b001);
    end
    i_start = 1'b0;
    start_mode(2'd0, "restart");
    check("restart_enable", 32'({o_enable, o_frame_cnt}), 32'({1'b1, 16'd0}));
    stop_mode("restart_stop");
    s_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
